// File: rtl/toggle_load_seq_if.sv
// Command/status bundle between a requester and the toggle/load sequencer.
// The master drives commands; the slave (the sequencer) drives the state and status.
interface toggle_load_seq_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             mode;
  logic             d;
  logic [CNT_W-1:0] n;
  logic             abort;
  logic             q;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] cnt;

  modport master (
    output start, mode, d, n, abort,
    input  q, busy, done, cnt
  );

  modport slave (
    input  start, mode, d, n, abort,
    output q, busy, done, cnt
  );
endinterface

// File: rtl/toggle_load_seq.sv
// Clocked load/toggle-burst sequencer for a single state bit q, with a
// start/busy/done handshake so no combinational loop is ever formed.

// Handshake invariants for the sequencer's status outputs.
module toggle_load_seq_chk (
  input logic clk,
  input logic rst,
  input logic busy,
  input logic done
);
  a_busy_done_exclusive: assert property (@(posedge clk) disable iff (rst) !(busy && done));
  a_done_single_pulse:   assert property (@(posedge clk) disable iff (rst) done |=> !done);
endmodule

module toggle_load_seq #(
  parameter int CNT_W = 8
) (
  input logic              clk,
  input logic              rst,
  toggle_load_seq_if.slave bus
);
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_TOGGLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  state_t           state_nxt_s;
  logic             q_r;
  logic             q_nxt_s;
  logic             d_r;
  logic             d_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             busy_r;
  logic             busy_nxt_s;
  logic             done_r;
  logic             done_nxt_s;

  // State register; busy/done are registered from the next state so they are pure Moore flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  // Next-state selection; a count of 1 or less in TOGGLE is treated as the last toggle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          if (!bus.mode) begin
            state_nxt_s = ST_LOAD;
          end else if (bus.n != CNT_ZERO) begin
            state_nxt_s = ST_TOGGLE;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD:   state_nxt_s = ST_DONE;
      ST_TOGGLE: begin
        if (bus.abort) begin
          state_nxt_s = ST_DONE;
        end else if (cnt_r <= CNT_ONE) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_TOGGLE;
        end
      end
      ST_DONE:   state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // Status decode of the state being entered.
  always_comb begin
    busy_nxt_s = 1'b0;
    done_nxt_s = 1'b0;
    case (state_nxt_s)
      ST_LOAD:   busy_nxt_s = 1'b1;
      ST_TOGGLE: busy_nxt_s = 1'b1;
      ST_DONE:   done_nxt_s = 1'b1;
      ST_IDLE:   busy_nxt_s = 1'b0;
      default: begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
      end
    endcase
  end

  // Datapath next values: load capture, q update and down-counter.
  always_comb begin
    q_nxt_s   = q_r;
    d_nxt_s   = d_r;
    cnt_nxt_s = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start && !bus.mode) begin
          d_nxt_s = bus.d;
        end else if (bus.start && (bus.n != CNT_ZERO)) begin
          cnt_nxt_s = bus.n;
        end else begin
          d_nxt_s = d_r;
        end
      end
      ST_LOAD: q_nxt_s = d_r;
      ST_TOGGLE: begin
        // Abort freezes both q and the remaining count for the requester to read.
        if (bus.abort) begin
          q_nxt_s = q_r;
        end else if (cnt_r <= CNT_ONE) begin
          q_nxt_s   = ~q_r;
          cnt_nxt_s = CNT_ZERO;
        end else begin
          q_nxt_s   = ~q_r;
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      ST_DONE: q_nxt_s = q_r;
      default: q_nxt_s = q_r;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r   <= 1'b0;
      d_r   <= 1'b0;
      cnt_r <= CNT_ZERO;
    end else begin
      q_r   <= q_nxt_s;
      d_r   <= d_nxt_s;
      cnt_r <= cnt_nxt_s;
    end
  end

  assign bus.q    = q_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.cnt  = cnt_r;

  toggle_load_seq_chk u_chk (
    .clk  (clk),
    .rst  (rst),
    .busy (busy_r),
    .done (done_r)
  );
endmodule

// File: tb/tb_toggle_load_seq.sv
// Directed plus randomized bench for toggle_load_seq; expected values come from
// a command-level timeline model (cycle index, toggle parity, remaining count).
module tb_toggle_load_seq;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  logic         q_m;
  logic [W-1:0] cnt_m;

  toggle_load_seq_if #(.CNT_W(W)) bus ();
  toggle_load_seq #(.CNT_W(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic eb, input logic ed, input logic eq,
                         input logic [W-1:0] ec);
    chk({tag, ".busy"}, W'(bus.busy), W'(eb));
    chk({tag, ".done"}, W'(bus.done), W'(ed));
    chk({tag, ".q"},    W'(bus.q),    W'(eq));
    chk({tag, ".cnt"},  bus.cnt,      ec);
  endtask

  task automatic quiet();
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  // Random command traffic that a busy sequencer must ignore.
  task automatic drive_noise(input bit en);
    bus.start = en ? 1'($urandom_range(0, 1)) : 1'b0;
    bus.mode  = 1'($urandom_range(0, 1));
    bus.d     = 1'($urandom_range(0, 1));
    bus.n     = W'($urandom);
  endtask

  // Issue one command in the current (idle) cycle and check its whole timeline.
  task automatic run_cmd(input string tag, input logic m, input logic dv,
                         input logic [W-1:0] nv, input int ak, input bit noise);
    int last;
    int tog;
    bus.start = 1'b1;
    bus.mode  = m;
    bus.d     = dv;
    bus.n     = nv;
    bus.abort = 1'b0;
    chk_all({tag, ".c0"}, 1'b0, 1'b0, q_m, cnt_m);
    tick();
    if (!m) begin
      drive_noise(noise);
      bus.abort = 1'($urandom_range(0, 1));
      chk_all({tag, ".load"}, 1'b1, 1'b0, q_m, cnt_m);
      tick();
      q_m = dv;
      drive_noise(noise);
      bus.abort = 1'b0;
      chk_all({tag, ".done"}, 1'b0, 1'b1, q_m, cnt_m);
    end else begin
      last = (nv == '0) ? 0 : ((ak > 0) ? ak : int'(nv));
      for (int c = 1; c <= last; c++) begin
        drive_noise(noise);
        bus.abort = (c == ak);
        chk_all($sformatf("%s.tog%0d", tag, c), 1'b1, 1'b0,
                q_m ^ ((c - 1) % 2 == 1), W'(int'(nv) - (c - 1)));
        tick();
      end
      tog = (nv == '0) ? 0 : ((ak > 0) ? ak - 1 : int'(nv));
      q_m = q_m ^ (tog % 2 == 1);
      if (nv != '0) cnt_m = (ak > 0) ? W'(int'(nv) - (ak - 1)) : '0;
      drive_noise(noise);
      bus.abort = 1'b0;
      chk_all({tag, ".done"}, 1'b0, 1'b1, q_m, cnt_m);
    end
    tick();
    quiet();
    chk_all({tag, ".idle"}, 1'b0, 1'b0, q_m, cnt_m);
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.mode  = 1'b0;
    bus.d     = 1'b0;
    bus.n     = '0;
    bus.abort = 1'b0;
    q_m       = 1'b0;
    cnt_m     = '0;
    tick();
    tick();
    chk_all("reset", 1'b0, 1'b0, 1'b0, '0);
    rst = 1'b0;
    tick();

    run_cmd("load1", 1'b0, 1'b1, '0, 0, 1'b0);
    run_cmd("load0", 1'b0, 1'b0, '0, 0, 1'b0);
    run_cmd("burst3", 1'b1, 1'b0, W'(3), 0, 1'b1);
    run_cmd("zero", 1'b1, 1'b1, '0, 0, 1'b1);
    run_cmd("abort", 1'b1, 1'b0, W'(10), 4, 1'b0);
    run_cmd("maxcnt", 1'b1, 1'b0, W'(15), 0, 1'b1);
    run_cmd("abort1", 1'b1, 1'b0, W'(6), 1, 1'b0);

    // Reset mid-burst when the counter reads 5.
    bus.start = 1'b1;
    bus.mode  = 1'b1;
    bus.n     = W'(8);
    tick();
    quiet();
    tick();
    tick();
    tick();
    chk({"midrst.cnt5"}, bus.cnt, W'(5));
    rst = 1'b1;
    tick();
    rst   = 1'b0;
    q_m   = 1'b0;
    cnt_m = '0;
    chk_all("midrst.after", 1'b0, 1'b0, 1'b0, '0);
    run_cmd("postrst", 1'b0, 1'b1, '0, 0, 1'b0);

    // Reset and start in the same cycle: the start must be dropped.
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.mode  = 1'b0;
    bus.d     = 1'b1;
    tick();
    rst = 1'b0;
    quiet();
    q_m   = 1'b0;
    cnt_m = '0;
    chk_all("rststart", 1'b0, 1'b0, 1'b0, '0);
    tick();
    chk_all("rststart.idle", 1'b0, 1'b0, 1'b0, '0);

    for (int i = 0; i < 40; i++) begin
      logic         rm;
      logic         rd;
      logic [W-1:0] rn;
      int           rk;
      rm = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      rn = W'($urandom);
      rk = (rn != '0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, int'(rn))) : 0;
      run_cmd($sformatf("rnd%0d", i), rm, rd, rn, rk, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
